// File: rtl/npc_seq_ctrl.sv
// Multi-cycle NPC sequencer: owns PC, fetches, latches inst, writes back addi, halts on ebreak/illegal/timeout.
// 4 cycles per addi with zero-wait memory; FETCH holds if_req_valid until if_req_ready, WAIT bounded by FETCH_TIMEOUT.
module npc_seq_ctrl #(
   parameter logic [31:0] RESET_PC      = 32'h8000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        if_req_valid,
   input  logic        if_req_ready,
   output logic [31:0] if_addr,
   input  logic        if_rsp_valid,
   input  logic [31:0] if_rsp_data,
   output logic [31:0] inst,
   input  logic [6:0]  dec_opcode,
   input  logic [2:0]  dec_funct3,
   output logic        rf_wen,
   output logic [31:0] pc,
   output logic [31:0] retire_cnt,
   output logic        halted,
   output logic [1:0]  halt_cause
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT   = 3'd1,
      S_DECODE = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
   localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
   localparam logic [2:0]  F3_ADDI     = 3'b000;
   localparam logic [7:0]  TMO_LAST    = 8'(FETCH_TIMEOUT - 1);

   localparam logic [1:0]  CAUSE_NONE    = 2'd0;
   localparam logic [1:0]  CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0]  CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] retire_q;
   logic        halted_q;
   logic [1:0]  cause_q;
   logic [7:0]  tmo_q;

   logic [31:0] pc_d;
   logic [31:0] retire_d;
   logic        is_ebreak;
   logic        is_addi;
   logic        tmo_hit;

   assign pc_d      = pc_q + 32'd4;
   assign retire_d  = retire_q + 32'd1;
   assign is_ebreak = (inst_q == EBREAK_WORD);
   assign is_addi   = (dec_opcode == OPC_OP_IMM) && (dec_funct3 == F3_ADDI);
   assign tmo_hit   = (tmo_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         inst_q   <= 32'd0;
         retire_q <= 32'd0;
         halted_q <= 1'b0;
         cause_q  <= CAUSE_NONE;
         tmo_q    <= 8'd0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (if_req_ready) begin
                  state_q <= S_WAIT;
                  tmo_q   <= 8'd0;
               end
            end
            S_WAIT: begin
               // A response on the last counted cycle beats the timeout.
               if (if_rsp_valid) begin
                  inst_q  <= if_rsp_data;
                  state_q <= S_DECODE;
               end else if (tmo_hit) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_TIMEOUT;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            S_DECODE: begin
               if (is_ebreak) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_EBREAK;
                  retire_q <= retire_d;
               end else if (is_addi) begin
                  state_q <= S_WB;
               end else begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_ILLEGAL;
               end
            end
            S_WB: begin
               pc_q     <= pc_d;
               retire_q <= retire_d;
               state_q  <= S_FETCH;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   // Gated by rst so neither strobe appears while the core is held in reset.
   assign if_req_valid = (state_q == S_FETCH) && !rst;
   assign rf_wen       = (state_q == S_WB) && !rst;
   assign if_addr      = pc_q;
   assign pc           = pc_q;
   assign inst         = inst_q;
   assign retire_cnt   = retire_q;
   assign halted       = halted_q;
   assign halt_cause   = cause_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Scoreboard bench for npc_seq_ctrl: sequential-word memory model, expected writebacks queued per test.
module tb_npc_seq_ctrl;

   localparam logic [31:0] RPC   = 32'h8000_0000;
   localparam logic [31:0] WRPC  = 32'hFFFF_FFFC;
   localparam logic [31:0] ADDI1 = 32'h0050_0093;
   localparam logic [31:0] ADDI2 = 32'h0030_8113;
   localparam logic [31:0] ADDI3 = 32'h0FF0_0193;
   localparam logic [31:0] EBRK  = 32'h0010_0073;
   localparam logic [31:0] ADD   = 32'h0000_0033;
   localparam logic [31:0] SLLI  = 32'h0010_9093;

   logic        clk;
   logic        rst;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;

   logic        if_req_valid, rf_wen, halted;
   logic [31:0] if_addr, inst, pc, retire_cnt;
   logic [1:0]  halt_cause;
   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;

   logic        w_if_req_valid, w_rf_wen, w_halted;
   logic [31:0] w_if_addr, w_inst, w_pc, w_retire_cnt;
   logic [1:0]  w_halt_cause;
   logic [6:0]  w_dec_opcode;
   logic [2:0]  w_dec_funct3;

   assign dec_opcode   = inst[6:0];
   assign dec_funct3   = inst[14:12];
   assign w_dec_opcode = w_inst[6:0];
   assign w_dec_funct3 = w_inst[14:12];

   npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .inst(inst), .dec_opcode(dec_opcode), .dec_funct3(dec_funct3),
      .rf_wen(rf_wen), .pc(pc), .retire_cnt(retire_cnt),
      .halted(halted), .halt_cause(halt_cause)
   );

   npc_seq_ctrl #(.RESET_PC(WRPC), .FETCH_TIMEOUT(16)) dut_w (
      .clk(clk), .rst(rst),
      .if_req_valid(w_if_req_valid), .if_req_ready(if_req_ready), .if_addr(w_if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .inst(w_inst), .dec_opcode(w_dec_opcode), .dec_funct3(w_dec_funct3),
      .rf_wen(w_rf_wen), .pc(w_pc), .retire_cnt(w_retire_cnt),
      .halted(w_halted), .halt_cause(w_halt_cause)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory knobs (written by the test process only)
   logic [31:0] prog[$];
   int          ready_stall;
   int          rsp_delay;
   bit          rsp_never;
   bit          inj_rsp;

   // memory state (written by the responder only)
   int          stall_left;
   int          wait_left;
   int          fetch_idx;
   bit          pending;
   logic [31:0] word;

   // kth accepted request returns prog[k]; both DUTs see identical inputs
   always @(negedge clk) begin
      if_rsp_valid = 1'b0;
      if (rst) begin
         if_req_ready = 1'b0;
         pending      = 1'b0;
         fetch_idx    = 0;
         stall_left   = ready_stall;
         if (inj_rsp) begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = ADDI1;
         end
      end else begin
         if (pending) begin
            if (wait_left == 0) begin
               if (!rsp_never) begin
                  if_rsp_valid = 1'b1;
                  if_rsp_data  = word;
               end
               pending = 1'b0;
            end else begin
               wait_left = wait_left - 1;
            end
         end
         if (if_req_valid) begin
            if (stall_left > 0) begin
               if_req_ready = 1'b0;
               stall_left   = stall_left - 1;
            end else begin
               if_req_ready = 1'b1;
            end
         end else begin
            if_req_ready = 1'b0;
         end
         if (if_req_valid && if_req_ready) begin
            pending    = 1'b1;
            wait_left  = rsp_delay;
            word       = (fetch_idx < prog.size()) ? prog[fetch_idx] : 32'd0;
            fetch_idx  = fetch_idx + 1;
            stall_left = ready_stall;
         end
      end
   end

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic [31:0] rc;
   } exp_t;

   exp_t sbq[$];
   int   errors;
   int   checks;
   int   cyc;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sbq.delete();
      tick();
      tick();
      rst = 1'b0;
      #1;
      cyc = 1;
   endtask

   task automatic push_wb(input int c, input logic [31:0] p, input logic [31:0] r);
      exp_t e;
      e.cyc = c;
      e.pc  = p;
      e.rc  = r;
      sbq.push_back(e);
   endtask

   task automatic run_until_halt(input int max_cyc);
      exp_t e;
      forever begin
         if (rf_wen === 1'b1) begin
            checks = checks + 1;
            if (sbq.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_wen: rf_wen=1 at cyc=%0d with nothing expected", cyc);
            end else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || pc !== e.pc || retire_cnt !== e.rc) begin
                  errors = errors + 1;
                  $display("FAIL wb: cyc=%0d pc=%h rc=%0d, expected cyc=%0d pc=%h rc=%0d",
                           cyc, pc, retire_cnt, e.cyc, e.pc, e.rc);
               end
            end
         end
         if (halted === 1'b1) break;
         if (cyc >= max_cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL halt_timeout: no halt by cyc=%0d", cyc);
            break;
         end
         tick();
      end
      checks = checks + 1;
      if (sbq.size() != 0) begin
         errors = errors + 1;
         $display("FAIL missing_wb: %0d writebacks never seen, expected 0", sbq.size());
      end
      sbq.delete();
   endtask

   task automatic set_mem(input int stall, input int dly, input bit never);
      ready_stall = stall;
      rsp_delay   = dly;
      rsp_never   = never;
      inj_rsp     = 1'b0;
   endtask

   task automatic test_reset();
      set_mem(0, 0, 1'b0);
      prog = '{ADDI1};
      rst = 1'b1;
      tick();
      tick();
      checks = checks + 1;
      if (if_req_valid !== 1'b0 || rf_wen !== 1'b0 || pc !== RPC || inst !== 32'd0 ||
          retire_cnt !== 32'd0 || halted !== 1'b0 || halt_cause !== 2'd0 || w_pc !== WRPC) begin
         errors = errors + 1;
         $display("FAIL reset_vals: vld=%b wen=%b pc=%h inst=%h rc=%0d h=%b c=%0d wpc=%h, expected 0 0 %h 0 0 0 0 %h",
                  if_req_valid, rf_wen, pc, inst, retire_cnt, halted, halt_cause, w_pc, RPC, WRPC);
      end
   endtask

   task automatic test_program();
      set_mem(0, 0, 1'b0);
      prog = '{ADDI1, ADDI2, EBRK};
      do_reset();
      push_wb(4, RPC, 32'd0);
      push_wb(8, RPC + 32'd4, 32'd1);
      run_until_halt(40);
      checks = checks + 1;
      if (halt_cause !== 2'd1 || retire_cnt !== 32'd3 || pc !== RPC + 32'd8 || cyc !== 12) begin
         errors = errors + 1;
         $display("FAIL prog_halt: cause=%0d rc=%0d pc=%h cyc=%0d, expected 1 3 %h 12",
                  halt_cause, retire_cnt, pc, cyc, RPC + 32'd8);
      end
   endtask

   task automatic test_ready_stall();
      set_mem(5, 0, 1'b0);
      prog = '{ADDI2, EBRK};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks = checks + 1;
         if (if_req_valid !== 1'b1 || if_addr !== RPC) begin
            errors = errors + 1;
            $display("FAIL stall_hold: cyc=%0d vld=%b addr=%h, expected 1 %h", cyc, if_req_valid, if_addr, RPC);
         end
         tick();
      end
      push_wb(9, RPC, 32'd0);
      run_until_halt(60);
      checks = checks + 1;
      if (halt_cause !== 2'd1 || retire_cnt !== 32'd2 || pc !== RPC + 32'd4) begin
         errors = errors + 1;
         $display("FAIL stall_halt: cause=%0d rc=%0d pc=%h, expected 1 2 %h", halt_cause, retire_cnt, pc, RPC + 32'd4);
      end
   endtask

   task automatic test_timeout();
      set_mem(0, 0, 1'b1);
      prog = '{ADDI1};
      do_reset();
      run_until_halt(40);
      checks = checks + 1;
      if (halt_cause !== 2'd3 || cyc !== 18 || retire_cnt !== 32'd0 || pc !== RPC) begin
         errors = errors + 1;
         $display("FAIL timeout: cause=%0d cyc=%0d rc=%0d pc=%h, expected 3 18 0 %h", halt_cause, cyc, retire_cnt, pc, RPC);
      end
      // response on the 16th WAIT cycle must still be taken
      set_mem(0, 15, 1'b0);
      prog = '{ADDI1, EBRK};
      do_reset();
      push_wb(19, RPC, 32'd0);
      run_until_halt(80);
      checks = checks + 1;
      if (halt_cause !== 2'd1 || retire_cnt !== 32'd2) begin
         errors = errors + 1;
         $display("FAIL last_cycle_rsp: cause=%0d rc=%0d, expected 1 2", halt_cause, retire_cnt);
      end
   endtask

   task automatic test_illegal();
      set_mem(0, 0, 1'b0);
      prog = '{ADD, ADDI1};
      do_reset();
      run_until_halt(30);
      checks = checks + 1;
      if (halt_cause !== 2'd2 || retire_cnt !== 32'd0 || pc !== RPC || cyc !== 4) begin
         errors = errors + 1;
         $display("FAIL illegal: cause=%0d rc=%0d pc=%h cyc=%0d, expected 2 0 %h 4", halt_cause, retire_cnt, pc, cyc, RPC);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks = checks + 1;
         if (if_req_valid !== 1'b0 || halted !== 1'b1 || rf_wen !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL halt_sticky: vld=%b halted=%b wen=%b, expected 0 1 0", if_req_valid, halted, rf_wen);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks = checks + 1;
      if (if_req_valid !== 1'b1 || if_addr !== RPC || halted !== 1'b0 || halt_cause !== 2'd0) begin
         errors = errors + 1;
         $display("FAIL halt_release: vld=%b addr=%h halted=%b cause=%0d, expected 1 %h 0 0",
                  if_req_valid, if_addr, halted, halt_cause, RPC);
      end
   endtask

   task automatic test_reset_in_wait();
      set_mem(0, 3, 1'b0);
      prog = '{ADDI1};
      do_reset();
      tick();
      checks = checks + 1;
      if (if_req_valid !== 1'b0 || halted !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL in_wait: vld=%b halted=%b, expected 0 0", if_req_valid, halted);
      end
      rst     = 1'b1;
      inj_rsp = 1'b1;
      tick();
      checks = checks + 1;
      if (pc !== RPC || inst !== 32'd0 || if_req_valid !== 1'b0 || retire_cnt !== 32'd0) begin
         errors = errors + 1;
         $display("FAIL rst_wait: pc=%h inst=%h vld=%b rc=%0d, expected %h 0 0 0", pc, inst, if_req_valid, retire_cnt, RPC);
      end
      rst       = 1'b0;
      inj_rsp   = 1'b0;
      rsp_delay = 0;
      #1;
      cyc = 1;
      checks = checks + 1;
      if (if_req_valid !== 1'b1 || if_addr !== RPC || inst !== 32'd0) begin
         errors = errors + 1;
         $display("FAIL rst_resume: vld=%b addr=%h inst=%h, expected 1 %h 0", if_req_valid, if_addr, inst, RPC);
      end
      push_wb(4, RPC, 32'd0);
      run_until_halt(30);
      checks = checks + 1;
      if (halt_cause !== 2'd2 || retire_cnt !== 32'd1) begin
         errors = errors + 1;
         $display("FAIL rst_after: cause=%0d rc=%0d, expected 2 1", halt_cause, retire_cnt);
      end
   endtask

   task automatic test_back_to_back();
      set_mem(0, 0, 1'b0);
      prog = '{ADDI1, ADDI2, ADDI3, SLLI};
      do_reset();
      for (int k = 0; k < 3; k++) push_wb(4 * (k + 1), RPC + 32'(4 * k), 32'(k));
      run_until_halt(60);
      checks = checks + 1;
      if (halt_cause !== 2'd2 || retire_cnt !== 32'd3 || pc !== RPC + 32'd12 || inst !== SLLI) begin
         errors = errors + 1;
         $display("FAIL b2b: cause=%0d rc=%0d pc=%h inst=%h, expected 2 3 %h %h",
                  halt_cause, retire_cnt, pc, inst, RPC + 32'd12, SLLI);
      end
   endtask

   task automatic test_wrap();
      set_mem(0, 0, 1'b0);
      prog = '{ADDI1, EBRK};
      do_reset();
      checks = checks + 1;
      if (w_if_req_valid !== 1'b1 || w_if_addr !== WRPC) begin
         errors = errors + 1;
         $display("FAIL wrap_first: vld=%b addr=%h, expected 1 %h", w_if_req_valid, w_if_addr, WRPC);
      end
      while (cyc < 5) tick();
      checks = checks + 1;
      if (w_if_req_valid !== 1'b1 || w_if_addr !== 32'd0 || w_pc !== 32'd0) begin
         errors = errors + 1;
         $display("FAIL wrap_next: vld=%b addr=%h pc=%h, expected 1 0 0", w_if_req_valid, w_if_addr, w_pc);
      end
      for (int i = 0; i < 10 && w_halted !== 1'b1; i++) tick();
      checks = checks + 1;
      if (w_halted !== 1'b1 || w_halt_cause !== 2'd1 || w_retire_cnt !== 32'd2 || w_pc !== 32'd0) begin
         errors = errors + 1;
         $display("FAIL wrap_halt: h=%b cause=%0d rc=%0d pc=%h, expected 1 1 2 0",
                  w_halted, w_halt_cause, w_retire_cnt, w_pc);
      end
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      cyc          = 0;
      rst          = 1'b1;
      if_req_ready = 1'b0;
      if_rsp_valid = 1'b0;
      if_rsp_data  = 32'd0;
      set_mem(0, 0, 1'b0);
      test_reset();
      test_program();
      test_ready_stall();
      test_timeout();
      test_illegal();
      test_reset_in_wait();
      test_back_to_back();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
